// File: rtl/ttt_win_scanner.sv
// Sequential N x N win scanner: evaluates one K-long window (row, col, dir) per clock.
// Optional EARLY_EXIT_EN: stop on the first winning window instead of a full scan.
module ttt_win_scanner #(
  parameter int N = 3,
  parameter int K = N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*N-1:0]   val,
  input  logic [N*N-1:0]   sym,
  output logic             busy,
  output logic             done,
  output logic [1:0]       gs,
  output logic             full
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(N*N);
  localparam logic [CW-1:0] LASTC = CW'(N-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [N*N-1:0]  val_s;
  logic [N*N-1:0]  sym_s;
  logic [CW-1:0]   row;
  logic [CW-1:0]   col;
  logic [1:0]      dir;
  logic            xw;
  logic            ow;

  logic            fits;
  logic            allx;
  logic            allo;
  logic            last;
  logic            stop;
  logic [IW-1:0]   idx;
  int              ri;
  int              ci;
  int              dr;
  int              dc;

  // Candidate window evaluation: dir selects the step (dr, dc) and the fit rule.
  always_comb begin
    ri   = int'(row);
    ci   = int'(col);
    dr   = 1;
    dc   = 0;
    fits = 1'b0;
    case (dir)
      2'd0: begin dr = 0; dc = 1;  fits = (ci + K <= N); end
      2'd1: begin dr = 1; dc = 0;  fits = (ri + K <= N); end
      2'd2: begin dr = 1; dc = 1;  fits = (ri + K <= N) && (ci + K <= N); end
      default: begin dr = 1; dc = -1; fits = (ri + K <= N) && (ci >= K - 1); end
    endcase
    allx = fits;
    allo = fits;
    idx  = '0;
    for (int i = 0; i < K; i++) begin
      idx  = fits ? IW'((ri + i*dr)*N + ci + i*dc) : '0;
      allx = allx & val_s[idx] & sym_s[idx];
      allo = allo & val_s[idx] & ~sym_s[idx];
    end
  end

  assign last = (row == LASTC) && (col == LASTC) && (dir == 2'd3);
`ifdef EARLY_EXIT_EN
  assign stop = last | allx | allo;
`else
  assign stop = last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      gs    <= 2'b00;
      full  <= 1'b0;
      val_s <= '0;
      sym_s <= '0;
      row   <= '0;
      col   <= '0;
      dir   <= '0;
      xw    <= 1'b0;
      ow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            val_s <= val;
            sym_s <= sym;
            xw    <= 1'b0;
            ow    <= 1'b0;
            row   <= '0;
            col   <= '0;
            dir   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (allx) xw <= 1'b1;
          if (allo) ow <= 1'b1;
          if (stop) begin
            state <= DONE;
          end else if (dir == 2'd3) begin
            dir <= 2'd0;
            if (col == LASTC) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            dir <= dir + 1'b1;
          end
        end
        DONE: begin
          gs    <= {ow, xw};
          full  <= &val_s;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_win_scanner.sv
// Self-checking bench for ttt_win_scanner: directed boards plus random boards
// checked against a direct enumeration of every K-long line on the board.
module tb_ttt_win_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start5;
  logic [8:0]  val3, sym3;
  logic [24:0] val5, sym5;
  logic        busy3, done3, full3;
  logic [1:0]  gs3;
  logic        busy5a, done5a, full5a;
  logic [1:0]  gs5a;
  logic        busy5b, done5b, full5b;
  logic [1:0]  gs5b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ttt_win_scanner #(.N(3), .K(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .val(val3), .sym(sym3),
    .busy(busy3), .done(done3), .gs(gs3), .full(full3));

  ttt_win_scanner #(.N(5), .K(4)) dut5a (
    .clk(clk), .rst(rst), .start(start5), .val(val5), .sym(sym5),
    .busy(busy5a), .done(done5a), .gs(gs5a), .full(full5a));

  ttt_win_scanner #(.N(5), .K(5)) dut5b (
    .clk(clk), .rst(rst), .start(start5), .val(val5), .sym(sym5),
    .busy(busy5b), .done(done5b), .gs(gs5b), .full(full5b));

  // Enumerate every line of k cells that lies wholly on the board.
  function automatic logic [1:0] ref_gs(input int n, input int k,
                                        input logic [63:0] v, input logic [63:0] s);
    int dr[4];
    int dc[4];
    logic xw, ow;
    int er, ec, nx, no, id;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    xw = 1'b0;
    ow = 1'b0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          er = r + (k-1)*dr[d];
          ec = c + (k-1)*dc[d];
          if (er < n && ec >= 0 && ec < n) begin
            nx = 0;
            no = 0;
            for (int i = 0; i < k; i++) begin
              id = (r + i*dr[d])*n + c + i*dc[d];
              if (v[id]) begin
                if (s[id]) nx++;
                else no++;
              end
            end
            if (nx == k) xw = 1'b1;
            if (no == k) ow = 1'b1;
          end
        end
    return {ow, xw};
  endfunction

  function automatic logic ref_full(input int n, input logic [63:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n*n; i++) if (v[i]) cnt++;
    return (cnt == n*n);
  endfunction

  // Start a 3x3 scan, return latency from the accepting edge and whether done lasted >1 cycle.
  task automatic run3(input logic [8:0] v, input logic [8:0] s, output int lat, output logic stuck);
    val3   = v;
    sym3   = s;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (done3 !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    stuck = done3;
  endtask

  task automatic run5(input logic [24:0] v, input logic [24:0] s, output int lat, output logic bsync);
    val5   = v;
    sym5   = s;
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    lat = 0;
    while (done5a !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    bsync = done5b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start3 = 1'b0; start5 = 1'b0;
    val3 = '1; sym3 = '1; val5 = '1; sym5 = '1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy3); end
    total++; if (done3 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done3); end
    total++; if (gs3 !== 2'b00) begin bad++; $display("FAIL reset_gs got=%b want=00", gs3); end
    total++; if (full3 !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full3); end
    total++; if ({busy5a, done5a, gs5a, full5a} !== 5'b0) begin bad++; $display("FAIL reset_n5 got=%b want=00000", {busy5a, done5a, gs5a, full5a}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_row0;
    int lat; logic stuck;
    run3(9'b000_000_111, 9'b000_000_111, lat, stuck);
    total++; if (lat !== 37) begin bad++; $display("FAIL row0_latency got=%0d want=37", lat); end
    total++; if (gs3 !== 2'b01) begin bad++; $display("FAIL row0_gs got=%b want=01", gs3); end
    total++; if (full3 !== 1'b0) begin bad++; $display("FAIL row0_full got=%b want=0", full3); end
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL row0_done_width got=%b want=0", stuck); end
    total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL row0_busy_after got=%b want=0", busy3); end
  endtask

  task automatic test_antidiag;
    int lat; logic stuck;
    run3(9'b111_111_111, 9'b110_101_011, lat, stuck);
    total++; if (gs3 !== 2'b10) begin bad++; $display("FAIL antidiag_gs got=%b want=10", gs3); end
    total++; if (full3 !== 1'b1) begin bad++; $display("FAIL antidiag_full got=%b want=1", full3); end
  endtask

  // Full board, no line; extra start and input churn during SCAN must not matter.
  task automatic test_busy_ignore;
    int cyc; int pulses; int first;
    val3 = 9'b111_111_111;
    sym3 = 9'b110_001_101;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    pulses = 0; first = -1;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (cyc == 5) begin start3 = 1'b1; val3 = 9'b000_000_111; sym3 = 9'b000_000_111; end
      if (cyc == 6) start3 = 1'b0;
      @(posedge clk); #1;
      if (done3 === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL busy_ignore_pulses got=%0d want=1", pulses); end
    total++; if (first !== 37) begin bad++; $display("FAIL busy_ignore_latency got=%0d want=37", first); end
    total++; if (gs3 !== 2'b00) begin bad++; $display("FAIL busy_ignore_gs got=%b want=00", gs3); end
    total++; if (full3 !== 1'b1) begin bad++; $display("FAIL busy_ignore_full got=%b want=1", full3); end
  endtask

  task automatic test_illegal;
    int lat; logic stuck;
    run3(9'b111_000_111, 9'b000_000_111, lat, stuck);
    total++; if (gs3 !== 2'b11) begin bad++; $display("FAIL illegal_gs got=%b want=11", gs3); end
    total++; if (lat !== 37) begin bad++; $display("FAIL illegal_latency got=%0d want=37", lat); end
  endtask

  // gs/full from the previous scan must survive a new start until its DONE.
  task automatic test_hold;
    int lat; logic stuck;
    run3(9'b000_000_111, 9'b000_000_111, lat, stuck);
    val3 = 9'b111_111_111; sym3 = 9'b000_000_000;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy3); end
    total++; if ({gs3, full3} !== 3'b010) begin bad++; $display("FAIL hold_outputs got=%b want=010", {gs3, full3}); end
    lat = 0;
    while (done3 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    total++; if ({gs3, full3} !== 3'b101) begin bad++; $display("FAIL hold_new_result got=%b want=101", {gs3, full3}); end
    @(posedge clk); #1;
  endtask

  task automatic test_n5;
    int lat; logic bsync;
    logic [24:0] v;
    v = '0;
    v[6] = 1'b1; v[12] = 1'b1; v[18] = 1'b1; v[24] = 1'b1;
    run5(v, v, lat, bsync);
    total++; if (lat !== 101) begin bad++; $display("FAIL n5_latency got=%0d want=101", lat); end
    total++; if (gs5a !== 2'b01) begin bad++; $display("FAIL n5_k4_gs got=%b want=01", gs5a); end
    total++; if (gs5b !== 2'b00) begin bad++; $display("FAIL n5_k5_gs got=%b want=00", gs5b); end
    total++; if (bsync !== 1'b1) begin bad++; $display("FAIL n5_k5_done got=%b want=1", bsync); end
  endtask

  task automatic test_reset_mid;
    int pulses; int lat; logic stuck;
    val3 = 9'b000_000_111; sym3 = 9'b000_000_111;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if ({busy3, done3, gs3, full3} !== 5'b0) begin bad++; $display("FAIL midreset_outputs got=%b want=00000", {busy3, done3, gs3, full3}); end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done3 === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", pulses); end
    total++; if (gs3 !== 2'b00) begin bad++; $display("FAIL midreset_gs got=%b want=00", gs3); end
    run3(9'b100_010_001, 9'b000_000_000, lat, stuck);
    total++; if (lat !== 37 || gs3 !== 2'b10) begin bad++; $display("FAIL midreset_restart got=lat%0d/gs%b want=lat37/gs10", lat, gs3); end
  endtask

  task automatic test_random;
    int lat; logic stuck; logic bsync;
    logic [8:0] v, s;
    logic [24:0] v5, s5;
    logic [1:0] eg;
    for (int t = 0; t < 40; t++) begin
      v = 9'($urandom) | 9'($urandom);
      s = 9'($urandom);
      run3(v, s, lat, stuck);
      eg = ref_gs(3, 3, 64'(v), 64'(s));
      total++; if (gs3 !== eg || full3 !== ref_full(3, 64'(v)) || lat !== 37)
        begin bad++; $display("FAIL rand3 v=%b s=%b got=gs%b/f%b/lat%0d want=gs%b/f%b/lat37", v, s, gs3, full3, lat, eg, ref_full(3, 64'(v))); end
    end
    for (int t = 0; t < 10; t++) begin
      v5 = 25'($urandom) | 25'($urandom) | 25'($urandom);
      s5 = 25'($urandom);
      run5(v5, s5, lat, bsync);
      eg = ref_gs(5, 4, 64'(v5), 64'(s5));
      total++; if (gs5a !== eg || full5a !== ref_full(5, 64'(v5)) || lat !== 101)
        begin bad++; $display("FAIL rand5k4 v=%h s=%h got=gs%b/lat%0d want=gs%b/lat101", v5, s5, gs5a, lat, eg); end
      eg = ref_gs(5, 5, 64'(v5), 64'(s5));
      total++; if (gs5b !== eg)
        begin bad++; $display("FAIL rand5k5 v=%h s=%h got=%b want=%b", v5, s5, gs5b, eg); end
    end
  endtask

  initial begin
    test_reset;
    test_row0;
    test_antidiag;
    test_busy_ignore;
    test_illegal;
    test_hold;
    test_n5;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
